// File: rtl/stdp_update_scheduler_pkg.sv
// Shared types and the base-2 STDP magnitude function for the update scheduler.
package stdp_pkg;

    localparam int DEF_W_WIDTH = 16;
    localparam int DEF_T_WIDTH = 8;

    typedef enum logic {
        LTD = 1'b0,
        LTP = 1'b1
    } stdp_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2
    } sched_state_e;

    // delta_w = amp >> (dt >> tau_shift), zero once the shift reaches the weight width
    function automatic logic [31:0] stdp_delta(input logic [31:0] amp,
                                               input logic [31:0] dt,
                                               input int unsigned tau_shift,
                                               input int unsigned w_width);
        logic [31:0] sh;
        sh = dt >> tau_shift;
        if (sh >= w_width) begin
            return '0;
        end
        return amp >> sh;
    endfunction

endpackage

// File: rtl/stdp_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
    import stdp_pkg::*;
#(
    parameter int NUM_SYN = 8,
    parameter int IDX_W   = 3
) (
    input  logic [NUM_SYN-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_SYN-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int unsigned N = NUM_SYN;

    // scan from the pointer outward and keep the first hit
    always_comb begin
        logic              found;
        logic [IDX_W-1:0]  cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IDX_W'((32'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stdp_update_scheduler.sv
// Time-shared pair-based STDP engine: spike timers, pending LTP/LTD requests,
// round-robin service into an IDLE/CALC/WRITE read-modify-write on the weight file.
module stdp_update_scheduler
    import stdp_pkg::*;
#(
    parameter int NUM_SYN   = 8,
    parameter int IDX_W     = 3,
    parameter int W_WIDTH   = DEF_W_WIDTH,
    parameter int T_WIDTH   = DEF_T_WIDTH,
    parameter int WINDOW    = 255,
    parameter int A_PLUS    = 32,
    parameter int A_MINUS   = 32,
    parameter int TAU_SHIFT = 2,
    parameter logic [W_WIDTH-1:0] W_INIT = W_WIDTH'(100),
    parameter logic [W_WIDTH-1:0] W_MAX  = '1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SYN-1:0] pre_spike,
    input  logic               post_spike,
    input  logic               learn_en,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_addr,
    input  logic [W_WIDTH-1:0] cfg_wdata,
    output logic [W_WIDTH-1:0] rd_data,
    output logic               busy,
    output logic               upd_valid,
    output logic [IDX_W-1:0]   upd_idx,
    output logic               upd_ltp,
    output logic [W_WIDTH-1:0] upd_weight,
    output logic [15:0]        drop_cnt
);

    localparam logic [T_WIDTH-1:0] T_MAX  = '1;
    localparam logic [31:0]        WIN    = 32'(WINDOW);
    localparam int unsigned        TAU_U  = TAU_SHIFT;
    localparam int unsigned        WW_U   = W_WIDTH;

    logic [T_WIDTH-1:0] pre_time [NUM_SYN];
    logic [T_WIDTH-1:0] post_time;
    logic [T_WIDTH-1:0] dt_ltd   [NUM_SYN];
    logic [T_WIDTH-1:0] dt_ltp   [NUM_SYN];
    logic [W_WIDTH-1:0] weight   [NUM_SYN];
    logic [NUM_SYN-1:0] ltd_pend, ltp_pend, ltd_set, ltp_set, clr_ltd, clr_ltp;
    logic [NUM_SYN-1:0] req, gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx, rr_ptr, cur_idx;
    logic [T_WIDTH-1:0] cur_dt;
    logic [W_WIDTH-1:0] cur_w, cur_dw, new_w;
    logic [W_WIDTH:0]   ltp_sum;
    logic [16:0]        drop_add, drop_sum;
    logic               grant_fire, serve_ltd;
    stdp_type_e         cur_type;
    sched_state_e       state, state_next;

    assign req     = ltd_pend | ltp_pend;
    assign rd_data = weight[cfg_addr];
    assign busy    = (state != IDLE) || (|req);

    rr_arbiter #(
        .NUM_SYN (NUM_SYN),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (gnt_onehot),
        .grant_idx (gnt_idx)
    );

    // saturating spike timers; a spike restarts its timer at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_time <= T_MAX;
            for (int unsigned i = 0; i < NUM_SYN; i++) pre_time[i] <= T_MAX;
        end else begin
            post_time <= post_spike ? '0 : ((post_time == T_MAX) ? T_MAX : post_time + 1'b1);
            for (int unsigned i = 0; i < NUM_SYN; i++)
                pre_time[i] <= pre_spike[i] ? '0 : ((pre_time[i] == T_MAX) ? T_MAX : pre_time[i] + 1'b1);
        end
    end

    // event capture against the pre-edge timer values, and overwrite counting
    always_comb begin
        ltd_set  = '0;
        ltp_set  = '0;
        drop_add = '0;
        for (int unsigned i = 0; i < NUM_SYN; i++) begin
            ltd_set[i] = learn_en & pre_spike[i] & (32'(post_time) < WIN);
            ltp_set[i] = learn_en & post_spike & (32'(pre_time[i]) < WIN);
            drop_add   = drop_add + 17'(ltd_set[i] & ltd_pend[i]) + 17'(ltp_set[i] & ltp_pend[i]);
        end
        drop_sum = {1'b0, drop_cnt} + drop_add;
    end

    // next state, grant decision and served-bit clears
    always_comb begin
        state_next = state;
        grant_fire = 1'b0;
        serve_ltd  = ltd_pend[gnt_idx];
        clr_ltd    = '0;
        clr_ltp    = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_fire = 1'b1;
                    state_next = CALC;
                    if (serve_ltd) clr_ltd = gnt_onehot;
                    else           clr_ltp = gnt_onehot;
                end
            end
            CALC:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // weight update: LTD floors at zero, LTP clamps at W_MAX using a carry bit
    always_comb begin
        ltp_sum = {1'b0, cur_w} + {1'b0, cur_dw};
        if (cur_type == LTP) new_w = (ltp_sum > {1'b0, W_MAX}) ? W_MAX : ltp_sum[W_WIDTH-1:0];
        else                 new_w = (cur_w > cur_dw) ? cur_w - cur_dw : '0;
    end

    // pending bits; a new set wins over a same-edge clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ltd_pend <= '0;
            ltp_pend <= '0;
            for (int unsigned i = 0; i < NUM_SYN; i++) begin
                dt_ltd[i] <= '0;
                dt_ltp[i] <= '0;
            end
        end else begin
            ltd_pend <= (ltd_pend & ~clr_ltd) | ltd_set;
            ltp_pend <= (ltp_pend & ~clr_ltp) | ltp_set;
            for (int unsigned i = 0; i < NUM_SYN; i++) begin
                if (ltd_set[i]) dt_ltd[i] <= post_time;
                if (ltp_set[i]) dt_ltp[i] <= pre_time[i];
            end
        end
    end

    // saturating count of overwritten pending events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= '0;
        else     drop_cnt <= (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // pipe registers; the weight is captured at grant so a same-edge host write is not seen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            cur_idx    <= '0;
            cur_type   <= LTD;
            cur_dt     <= '0;
            cur_w      <= '0;
            cur_dw     <= '0;
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_ltp    <= 1'b0;
            upd_weight <= '0;
        end else begin
            upd_valid <= 1'b0;
            if (grant_fire) begin
                cur_idx  <= gnt_idx;
                cur_type <= serve_ltd ? LTD : LTP;
                cur_dt   <= serve_ltd ? dt_ltd[gnt_idx] : dt_ltp[gnt_idx];
                cur_w    <= weight[gnt_idx];
                rr_ptr   <= (gnt_idx == IDX_W'(NUM_SYN - 1)) ? '0 : gnt_idx + 1'b1;
            end
            if (state == CALC)
                cur_dw <= W_WIDTH'(stdp_delta((cur_type == LTP) ? 32'(A_PLUS) : 32'(A_MINUS),
                                              32'(cur_dt), TAU_U, WW_U));
            if (state == WRITE) begin
                upd_valid  <= 1'b1;
                upd_idx    <= cur_idx;
                upd_ltp    <= (cur_type == LTP);
                upd_weight <= new_w;
            end
        end
    end

    // weight file: host writes only in IDLE, pipe commits in WRITE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SYN; i++) weight[i] <= W_INIT;
        end else if (state == IDLE && cfg_we) begin
            weight[cfg_addr] <= cfg_wdata;
        end else if (state == WRITE) begin
            weight[cur_idx] <= new_w;
        end
    end

endmodule
